// File: rtl/buffer_pkg.sv
// Shared definitions for the circular Buffer and its pointer/handshake controller.
package buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  // Occupancy counter must hold 0..size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/buffer_ctrl_if.sv
// Producer/consumer handshake plus Buffer address/load bundle for buffer_ctrl.
interface buffer_ctrl_if #(
  parameter int SIZE = 16
);
  import buffer_pkg::*;

  localparam int BIT = $clog2(SIZE);
  localparam int CNT = cnt_width(SIZE);

  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic           ld;
  logic [BIT-1:0] write_add;
  logic [BIT-1:0] read_add;
  logic [CNT-1:0] level;
  logic           full;
  logic           empty;

  modport master (
    output flush, in_valid, out_ready,
    input  in_ready, out_valid, ld, write_add, read_add, level, full, empty
  );

  modport slave (
    input  flush, in_valid, out_ready,
    output in_ready, out_valid, ld, write_add, read_add, level, full, empty
  );

endinterface

// File: rtl/ptr_counter.sv
// Modulo-2^BIT pointer advancing by STEP; async reset, synchronous clear wins over advance.
module ptr_counter #(
  parameter int BIT  = 4,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  output logic [BIT-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr + BIT'(STEP);
    end
  end

endmodule

// File: rtl/buffer_ctrl.sv
// Pointer/occupancy controller for a K-in/J-out circular Buffer; readiness is decoded
// from the registered level only, so freed space is never reused in the same cycle.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int K    = 4,
  parameter int J    = 4
) (
  input  logic         clk,
  input  logic         rst,
  buffer_ctrl_if.slave bus
);

  localparam int CNT = cnt_width(SIZE);

  logic [CNT-1:0] level_q;
  logic [CNT:0]   space;
  logic [CNT:0]   level_next;
  logic           wr_acc;
  logic           rd_acc;
  state_t         state;

  assign space         = (CNT+1)'(SIZE) - {1'b0, level_q};
  assign bus.in_ready  = (space >= (CNT+1)'(K)) && !bus.flush;
  assign bus.out_valid = ({1'b0, level_q} >= (CNT+1)'(J)) && !bus.flush;

  assign wr_acc = bus.in_valid  && bus.in_ready;
  assign rd_acc = bus.out_valid && bus.out_ready;
  assign bus.ld = wr_acc;

  assign level_next = {1'b0, level_q}
                    + (wr_acc ? (CNT+1)'(K) : '0)
                    - (rd_acc ? (CNT+1)'(J) : '0);

  ptr_counter #(.BIT($bits(bus.write_add)), .STEP(K)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .adv (wr_acc),
    .ptr (bus.write_add)
  );

  ptr_counter #(.BIT($bits(bus.read_add)), .STEP(J)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .adv (rd_acc),
    .ptr (bus.read_add)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      state   <= ST_EMPTY;
    end else if (bus.flush) begin
      level_q <= '0;
      state   <= ST_EMPTY;
    end else begin
      level_q <= level_next[CNT-1:0];
      if (level_next == '0) begin
        state <= ST_EMPTY;
      end else if (level_next == (CNT+1)'(SIZE)) begin
        state <= ST_FULL;
      end else begin
        state <= ST_PARTIAL;
      end
    end
  end

  assign bus.level = level_q;
  assign bus.empty = (state == ST_EMPTY);
  assign bus.full  = (state == ST_FULL);

endmodule
